// File: rtl/lvds_frame_rx.sv
// Receive-side deframer for the 10-bit LVDS link: hunts for SYNC_WORD, checks
// each 4-word frame and delivers {hi,lo} voltage samples once the link is aligned.
module lvds_frame_rx #(
  parameter logic [9:0] SYNC_WORD = 10'h0FC,
  parameter int         ALIGN_CNT = 3,
  parameter int         ERR_LIMIT = 2
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic [9:0]  datarx,
  input  logic        datarx_en,
  input  logic        lock_n,
  output logic [15:0] ad_voltage,
  output logic        ad_voltage_valid,
  output logic        aligned,
  output logic        frame_err,
  output logic [15:0] err_cnt,
  output logic [1:0]  state_o
);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] GET_HI  = 2'd1;
  localparam logic [1:0] GET_LO  = 2'd2;
  localparam logic [1:0] GET_CHK = 2'd3;

  localparam logic [3:0] ALIGN_N = 4'(ALIGN_CNT);
  localparam logic [3:0] ERR_N   = 4'(ERR_LIMIT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [3:0]  good_run_q, good_run_d;
  logic [3:0]  bad_run_q, bad_run_d;
  logic        aligned_q, aligned_d;
  logic [15:0] ad_voltage_q, ad_voltage_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic [1:0]  tag;
  logic [7:0]  payload;
  logic        is_sync;
  logic        good_frame;
  logic        bad_frame;
  logic [3:0]  good_inc;
  logic [3:0]  bad_inc;

  assign tag      = datarx[9:8];
  assign payload  = datarx[7:0];
  assign is_sync  = (datarx == SYNC_WORD);
  assign good_inc = (good_run_q == ALIGN_N) ? good_run_q : good_run_q + 4'd1;
  assign bad_inc  = (bad_run_q == ERR_N) ? bad_run_q : bad_run_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    good_run_d   = good_run_q;
    bad_run_d    = bad_run_q;
    aligned_d    = aligned_q;
    ad_voltage_d = ad_voltage_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
    err_cnt_d    = err_cnt_q;
    good_frame   = 1'b0;
    bad_frame    = 1'b0;

    if (lock_n) begin
      // Lock loss silently discards any partial frame.
      state_d    = HUNT;
      aligned_d  = 1'b0;
      good_run_d = 4'd0;
      bad_run_d  = 4'd0;
    end else if (datarx_en) begin
      case (state_q)
        HUNT: begin
          if (is_sync) state_d = GET_HI;
        end
        GET_HI: begin
          if (is_sync) begin
            bad_frame = 1'b1;
            state_d   = GET_HI;
          end else if (tag == 2'b01) begin
            hi_d    = payload;
            state_d = GET_LO;
          end else begin
            bad_frame = 1'b1;
            state_d   = HUNT;
          end
        end
        GET_LO: begin
          if (is_sync) begin
            bad_frame = 1'b1;
            state_d   = GET_HI;
          end else if (tag == 2'b10) begin
            lo_d    = payload;
            state_d = GET_CHK;
          end else begin
            bad_frame = 1'b1;
            state_d   = HUNT;
          end
        end
        default: begin
          if (is_sync) begin
            bad_frame = 1'b1;
            state_d   = GET_HI;
          end else if (tag == 2'b11 && payload == (hi_q ^ lo_q)) begin
            good_frame = 1'b1;
            state_d    = HUNT;
          end else begin
            bad_frame = 1'b1;
            state_d   = HUNT;
          end
        end
      endcase

      if (good_frame) begin
        good_run_d = good_inc;
        bad_run_d  = 4'd0;
        if (aligned_q || good_inc == ALIGN_N) begin
          aligned_d    = 1'b1;
          ad_voltage_d = {hi_q, lo_q};
          valid_d      = 1'b1;
        end
      end

      if (bad_frame) begin
        frame_err_d = 1'b1;
        err_cnt_d   = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
        good_run_d  = 4'd0;
        bad_run_d   = bad_inc;
        if (bad_inc == ERR_N) aligned_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      hi_q         <= 8'd0;
      lo_q         <= 8'd0;
      good_run_q   <= 4'd0;
      bad_run_q    <= 4'd0;
      aligned_q    <= 1'b0;
      ad_voltage_q <= 16'd0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      good_run_q   <= good_run_d;
      bad_run_q    <= bad_run_d;
      aligned_q    <= aligned_d;
      ad_voltage_q <= ad_voltage_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign ad_voltage       = ad_voltage_q;
  assign ad_voltage_valid = valid_q;
  assign aligned          = aligned_q;
  assign frame_err        = frame_err_q;
  assign err_cnt          = err_cnt_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_lvds_frame_rx.sv
// Directed bench for lvds_frame_rx: word-level drivers, a strobe scoreboard and
// immediate-assertion checks after each interesting word.
module tb_lvds_frame_rx;

  localparam logic [9:0] SYNC = 10'h0FC;

  logic        sysclk;
  logic        rst;
  logic [9:0]  datarx;
  logic        datarx_en;
  logic        lock_n;
  logic [15:0] ad_voltage;
  logic        ad_voltage_valid;
  logic        aligned;
  logic        frame_err;
  logic [15:0] err_cnt;
  logic [1:0]  state_o;

  int          errors = 0;
  int          checks = 0;
  bit          gap = 1'b0;
  string       step = "reset";
  logic [15:0] exp_q[$];

  lvds_frame_rx dut (
    .sysclk           (sysclk),
    .rst              (rst),
    .datarx           (datarx),
    .datarx_en        (datarx_en),
    .lock_n           (lock_n),
    .ad_voltage       (ad_voltage),
    .ad_voltage_valid (ad_voltage_valid),
    .aligned          (aligned),
    .frame_err        (frame_err),
    .err_cnt          (err_cnt),
    .state_o          (state_o)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  // Every strobe must match the next queued sample; strobes with nothing queued are errors.
  always @(negedge sysclk) begin
    if (ad_voltage_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
      else check("strobe_value", {16'd0, ad_voltage}, {16'd0, exp_q.pop_front()});
    end
  end

  // Drive one word; returns 1 time unit after the edge that consumed it.
  task automatic send(input logic [9:0] w);
    if (gap) begin
      @(negedge sysclk);
      datarx    = SYNC;
      datarx_en = 1'b0;
      @(posedge sysclk);
    end
    @(negedge sysclk);
    datarx    = w;
    datarx_en = 1'b1;
    @(posedge sysclk);
    #1;
  endtask

  task automatic send_tail(input logic [7:0] hi, input logic [7:0] lo, input bit strobe);
    send({2'b01, hi});
    send({2'b10, lo});
    if (strobe) exp_q.push_back({hi, lo});
    send({2'b11, hi ^ lo});
    check("valid", {31'd0, ad_voltage_valid}, {31'd0, strobe});
    if (strobe) check("ad_voltage", {16'd0, ad_voltage}, {16'd0, hi, lo});
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input bit strobe);
    send(SYNC);
    send_tail(hi, lo, strobe);
  endtask

  initial begin
    rst = 1'b1; lock_n = 1'b0; datarx_en = 1'b0; datarx = 10'd0;
    repeat (2) @(posedge sysclk);
    #1;
    check("ad_voltage", {16'd0, ad_voltage}, 32'd0);
    check("valid", {31'd0, ad_voltage_valid}, 32'd0);
    check("aligned", {31'd0, aligned}, 32'd0);
    check("frame_err", {31'd0, frame_err}, 32'd0);
    check("err_cnt", {16'd0, err_cnt}, 32'd0);
    check("state", {30'd0, state_o}, 32'd0);
    @(negedge sysclk);
    rst = 1'b0;

    step = "t1_align";
    send_frame(8'h12, 8'h34, 1'b0);
    check("aligned", {31'd0, aligned}, 32'd0);
    send_frame(8'hAB, 8'hCD, 1'b0);
    check("aligned", {31'd0, aligned}, 32'd0);
    send_frame(8'h00, 8'hFF, 1'b1);
    check("aligned", {31'd0, aligned}, 32'd1);

    step = "t2_bad_chk";
    send(SYNC);
    send({2'b01, 8'h12});
    send({2'b10, 8'h34});
    send({2'b11, 8'h27});
    check("frame_err", {31'd0, frame_err}, 32'd1);
    check("err_cnt", {16'd0, err_cnt}, 32'd1);
    check("aligned", {31'd0, aligned}, 32'd1);
    check("valid", {31'd0, ad_voltage_valid}, 32'd0);
    send(SYNC);
    check("frame_err_pulse", {31'd0, frame_err}, 32'd0);
    send_tail(8'h5A, 8'h5A, 1'b1);

    step = "t3_unalign";
    send(SYNC);
    send({2'b00, 8'h11});
    check("frame_err", {31'd0, frame_err}, 32'd1);
    check("err_cnt", {16'd0, err_cnt}, 32'd2);
    check("aligned", {31'd0, aligned}, 32'd1);
    send(SYNC);
    send({2'b00, 8'h22});
    check("err_cnt", {16'd0, err_cnt}, 32'd3);
    check("aligned", {31'd0, aligned}, 32'd0);
    send_frame(8'h01, 8'h01, 1'b0);
    send_frame(8'h02, 8'h02, 1'b0);
    check("aligned", {31'd0, aligned}, 32'd0);
    send_frame(8'h03, 8'h04, 1'b1);
    check("aligned", {31'd0, aligned}, 32'd1);

    step = "t4_resync";
    send(SYNC);
    send({2'b01, 8'h77});
    send(SYNC);
    check("frame_err", {31'd0, frame_err}, 32'd1);
    check("err_cnt", {16'd0, err_cnt}, 32'd4);
    check("state", {30'd0, state_o}, 32'd1);
    send_tail(8'h01, 8'h02, 1'b1);
    check("aligned", {31'd0, aligned}, 32'd1);

    step = "t5_lock_loss";
    send(SYNC);
    send({2'b01, 8'h99});
    lock_n = 1'b1;
    send({2'b10, 8'h00});
    check("aligned", {31'd0, aligned}, 32'd0);
    check("state", {30'd0, state_o}, 32'd0);
    check("frame_err", {31'd0, frame_err}, 32'd0);
    send({2'b11, 8'h99});
    check("err_cnt", {16'd0, err_cnt}, 32'd4);
    check("ad_voltage", {16'd0, ad_voltage}, 32'h0102);
    lock_n = 1'b0;
    send_frame(8'h33, 8'h44, 1'b0);
    check("ad_voltage", {16'd0, ad_voltage}, 32'h0102);
    check("aligned", {31'd0, aligned}, 32'd0);

    step = "t6_gapped";
    gap = 1'b1;
    send_frame(8'h10, 8'h20, 1'b0);
    check("aligned", {31'd0, aligned}, 32'd0);
    send_frame(8'hC3, 8'h3C, 1'b1);
    check("aligned", {31'd0, aligned}, 32'd1);
    send_frame(8'hDE, 8'hAD, 1'b1);
    send(SYNC);
    send({2'b01, 8'h55});
    #2 rst = 1'b1;
    #1;
    check("rst_ad_voltage", {16'd0, ad_voltage}, 32'd0);
    check("rst_aligned", {31'd0, aligned}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("rst_state", {30'd0, state_o}, 32'd0);
    check("rst_valid", {31'd0, ad_voltage_valid}, 32'd0);
    @(negedge sysclk);
    rst = 1'b0;
    datarx_en = 1'b0;
    send_frame(8'h11, 8'h22, 1'b0);
    check("aligned", {31'd0, aligned}, 32'd0);
    check("err_cnt", {16'd0, err_cnt}, 32'd0);

    step = "end";
    gap = 1'b0;
    @(negedge sysclk);
    datarx_en = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
